// File: rtl/alu_op_sequencer.sv
// Command front-end for the combinational lab ALU: accepts one operation, holds the ALU
// inputs for SETTLE cycles, captures the result, optionally self-checks it and returns it.
module alu_op_sequencer #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_check,
    input  logic [WIDTH-1:0] cmd_expect,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_binvert,
    output logic             alu_carryin,
    output logic [1:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_mismatch,
    output logic [15:0]      op_count,
    output logic [15:0]      err_count
);
    // SETTLE of 0 is treated as 1 so the ALU always gets at least one full cycle.
    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int CW = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg;
    logic              check_reg;
    logic [WIDTH-1:0]  expect_reg;
    logic [WIDTH-1:0]  alu_a_reg, alu_b_reg;
    logic              alu_binvert_reg, alu_carryin_reg;
    logic [1:0]        alu_operation_reg;
    logic [WIDTH-1:0]  rsp_result_reg;
    logic              rsp_carry_reg, rsp_mismatch_reg;
    logic [15:0]       op_count_reg, err_count_reg;
    logic              accept, capture, mismatch_now;

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = DRIVE;
            end
            DRIVE: begin
                if (cnt_reg == '0) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept       = cmd_valid && (state_reg == IDLE);
    assign capture      = (state_reg == DRIVE) && (cnt_reg == '0);
    assign mismatch_now = check_reg && (alu_result != expect_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            check_reg         <= 1'b0;
            expect_reg        <= '0;
            alu_a_reg         <= '0;
            alu_b_reg         <= '0;
            alu_binvert_reg   <= 1'b0;
            alu_carryin_reg   <= 1'b0;
            alu_operation_reg <= 2'b00;
            rsp_result_reg    <= '0;
            rsp_carry_reg     <= 1'b0;
            rsp_mismatch_reg  <= 1'b0;
            op_count_reg      <= '0;
            err_count_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg           <= CNT_LOAD;
                check_reg         <= cmd_check;
                expect_reg        <= cmd_expect;
                alu_a_reg         <= cmd_a;
                alu_b_reg         <= cmd_b;
                // SUB is ADD with b inverted and a carry-in of one.
                alu_binvert_reg   <= (cmd_op == 2'b11);
                alu_carryin_reg   <= (cmd_op == 2'b11);
                alu_operation_reg <= cmd_op[1] ? 2'b10 : cmd_op;
            end else if (state_reg == DRIVE && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            if (capture) begin
                rsp_result_reg   <= alu_result;
                rsp_carry_reg    <= alu_carryout;
                rsp_mismatch_reg <= mismatch_now;
                op_count_reg     <= op_count_reg + 16'd1;
                if (mismatch_now && err_count_reg != 16'hFFFF)
                    err_count_reg <= err_count_reg + 16'd1;
            end
        end
    end

    assign alu_a         = alu_a_reg;
    assign alu_b         = alu_b_reg;
    assign alu_binvert   = alu_binvert_reg;
    assign alu_carryin   = alu_carryin_reg;
    assign alu_operation = alu_operation_reg;
    assign rsp_result    = rsp_result_reg;
    assign rsp_carry     = rsp_carry_reg;
    assign rsp_mismatch  = rsp_mismatch_reg;
    assign op_count      = op_count_reg;
    assign err_count     = err_count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU closes the loop, a scoreboard queue holds
// expected responses and a negedge monitor compares each accepted response.
module tb_alu_op_sequencer;
    localparam int W = 32;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_check;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_a, cmd_b, cmd_expect;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic          alu_binvert, alu_carryin, alu_carryout;
    logic [1:0]    alu_operation;
    logic          rsp_valid, rsp_ready, rsp_carry, rsp_mismatch;
    logic [W-1:0]  rsp_result;
    logic [15:0]   op_count, err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] result;
        logic         carry;
        logic         mismatch;
        logic [15:0]  opc;
        logic [15:0]  errc;
    } exp_t;
    exp_t sb[$];
    logic [15:0] m_opc = 16'd0;
    logic [15:0] m_errc = 16'd0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .SETTLE(S)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_check(cmd_check), .cmd_expect(cmd_expect),
        .alu_a(alu_a), .alu_b(alu_b), .alu_binvert(alu_binvert), .alu_carryin(alu_carryin),
        .alu_operation(alu_operation), .alu_result(alu_result), .alu_carryout(alu_carryout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_mismatch(rsp_mismatch),
        .op_count(op_count), .err_count(err_count)
    );

    // Lab ALU: AND/OR/adder with optional b inversion; CarryOut always comes from the adder.
    logic [W-1:0] bb;
    logic [W:0]   sum;
    always_comb begin
        bb           = alu_binvert ? ~alu_b : alu_b;
        sum          = {1'b0, alu_a} + {1'b0, bb} + {{W{1'b0}}, alu_carryin};
        alu_carryout = sum[W];
        case (alu_operation)
            2'b00:   alu_result = alu_a & bb;
            2'b01:   alu_result = alu_a | bb;
            2'b10:   alu_result = sum[W-1:0];
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic; carry is the unsigned carry of a+b, or no-borrow for SUB.
    task automatic ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic carry);
        longint unsigned s;
        s = longint'(a) + longint'(b);
        carry = (s > 64'h0000_0000_FFFF_FFFF);
        case (op)
            2'd0: res = a & b;
            2'd1: res = a | b;
            2'd2: res = a + b;
            default: begin
                res   = a - b;
                carry = (a >= b);
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_result", rsp_result, e.result);
                chk("rsp_carry", rsp_carry, e.carry);
                chk("rsp_mismatch", rsp_mismatch, e.mismatch);
                chk("op_count", op_count, e.opc);
                chk("err_count", err_count, e.errc);
                $display("rsp result=%h carry=%b mismatch=%b op_count=%h err_count=%h",
                         rsp_result, rsp_carry, rsp_mismatch, op_count, err_count);
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic chkb, input logic [W-1:0] expv, input bit bp);
        exp_t e;
        int n;
        logic binv;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        cmd_check = chkb; cmd_expect = expv;
        rsp_ready = bp ? 1'b0 : 1'b1;
        ref_op(op, a, b, e.result, e.carry);
        e.mismatch = chkb && (e.result != expv);
        m_opc = m_opc + 16'd1;
        if (e.mismatch && m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
        e.opc = m_opc; e.errc = m_errc;
        sb.push_back(e);
        $display("cmd op=%0d a=%h b=%h check=%b expect=%h", op, a, b, chkb, expv);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        binv = (op == 2'd3);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_operation", alu_operation, (op == 2'd3) ? 2'd2 : op);
        n = 0;
        while (!rsp_valid && n < 20) begin
            chk("binvert_drive", alu_binvert, binv);
            chk("carryin_drive", alu_carryin, binv);
            chk("cmd_ready_drive", cmd_ready, 0);
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", n, S);
        if (bp) begin
            for (int i = 0; i < 5; i++) begin
                cmd_valid = (i == 2);
                cmd_op = 2'd1; cmd_a = ~a; cmd_b = ~b;
                @(negedge clk);
                chk("bp_rsp_valid", rsp_valid, 1);
                chk("bp_cmd_ready", cmd_ready, 0);
                chk("bp_rsp_result", rsp_result, e.result);
                chk("bp_rsp_carry", rsp_carry, e.carry);
                chk("bp_alu_a", alu_a, a);
            end
            cmd_valid = 1'b0;
            @(posedge clk);
            #1 rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a, b, r, ev;
        logic         c, ck;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = '0; cmd_b = '0;
        cmd_check = 1'b0; cmd_expect = '0; rsp_ready = 1'b1;
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp", {rsp_result, rsp_carry, rsp_mismatch}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_binvert, alu_carryin, alu_operation}, 0);
        chk("rst_counts", {op_count, err_count}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++)
            do_op(2'(i), 32'ha5a5a5a5, 32'h00000001, 1'b0, '0, 1'b0);
        chk("op_count_after4", op_count, 16'd4);

        do_op(2'd3, 32'h00000000, 32'h00000001, 1'b0, '0, 1'b0);

        do_op(2'd0, 32'ha5a5a5a5, 32'h00000001, 1'b1, 32'h00000000, 1'b0);
        do_op(2'd0, 32'ha5a5a5a5, 32'h00000001, 1'b1, 32'h00000001, 1'b0);
        chk("err_count_selfcheck", err_count, 16'd1);

        do_op(2'd2, 32'h12345678, 32'h9abcdef0, 1'b1, 32'hdeadbeef, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = (i % 10 == 0) ? 32'hffffffff : $urandom;
            b  = (i % 7 == 0) ? 32'h00000000 : $urandom;
            ck = 1'($urandom_range(0, 1));
            ref_op(op, a, b, r, c);
            ev = ($urandom_range(0, 1) == 1) ? r : $urandom;
            do_op(op, a, b, ck, ev, (i % 9 == 4));
        end

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a = 32'h11111111; cmd_b = 32'h22222222;
        cmd_check = 1'b1; cmd_expect = '0;
        $display("cmd op=2 a=11111111 b=22222222 (reset during DRIVE)");
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_alu", {alu_a, alu_b, alu_binvert, alu_carryin, alu_operation}, 0);
        chk("midrst_counts", {op_count, err_count}, 0);
        m_opc = 16'd0; m_errc = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < S + 4; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", rsp_valid, 0);
        end

        @(negedge clk);
        force dut.op_count_reg = 16'hffff;
        force dut.err_count_reg = 16'hfffe;
        #1;
        release dut.op_count_reg;
        release dut.err_count_reg;
        m_opc = 16'hffff; m_errc = 16'hfffe;
        do_op(2'd1, 32'h0000f0f0, 32'h00000f0f, 1'b1, 32'h00000000, 1'b0);
        do_op(2'd3, 32'h00000010, 32'h00000001, 1'b1, 32'h00000000, 1'b0);
        chk("err_count_sat", err_count, 16'hffff);
        chk("op_count_wrap", op_count, 16'h0001);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
